// File: rtl/trunc_seq_pkg.sv
// Shared types and constants for the trunc_seq packet truncation controller.
// Optional build macro: TRUNC_SEQ_ROUND_EN (round-half-up before clearing LSBs).
package trunc_seq_pkg;

  localparam int DIN_DEF   = 16;
  localparam int NW_DEF    = 5;
  localparam int LEN_W_DEF = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Bit offset of the nbits field inside cfg_data.
  function automatic int nbits_lsb();
    return 0;
  endfunction

  // Bit offset of the len field inside cfg_data; it sits directly above nbits.
  function automatic int len_lsb(input int nw);
    return nw;
  endfunction

endpackage

// File: rtl/trunc_seq_mask.sv
// Combinational LSB clear for one data beat.
// With TRUNC_SEQ_ROUND_EN defined the beat is rounded half-up before the
// clear, saturating to all-ones (low bits cleared) on carry-out. Without the
// macro no adder exists and the beat is simply masked.
// nbits is expected to be already clipped to the range 0..DIN.
module trunc_seq_mask
  import trunc_seq_pkg::*;
#(
  parameter int DIN = DIN_DEF,
  parameter int NW  = NW_DEF
) (
  input  logic [DIN-1:0] data,
  input  logic [NW-1:0]  nbits,
  output logic [DIN-1:0] masked
);

  // nbits == DIN shifts every one out, so the keep mask becomes zero.
  logic [DIN-1:0] keep;
  assign keep = {DIN{1'b1}} << nbits;

`ifdef TRUNC_SEQ_ROUND_EN
  localparam logic [NW-1:0] DIN_NW = NW'(DIN);

  logic [DIN:0] half;
  logic [DIN:0] sum;

  // Add half an LSB of the kept part, then clear; full-width clear skips rounding.
  always_comb begin
    half = '0;
    if (nbits != '0 && nbits < DIN_NW) begin
      half = {{DIN{1'b0}}, 1'b1} << (nbits - 1'b1);
    end
    sum = {1'b0, data} + half;
    if (sum[DIN]) begin
      masked = keep;
    end else begin
      masked = sum[DIN-1:0] & keep;
    end
  end
`else
  assign masked = data & keep;
`endif

endmodule

// File: rtl/trunc_seq.sv
// Packet-level controller for the LSB truncation datapath.
// Accepts {len, nbits} on the cfg stream, then passes exactly len+1 beats
// from din to dout with the low nbits (clipped to DIN) cleared.
// Optional build macro: TRUNC_SEQ_ROUND_EN (selects rounding in trunc_seq_mask).
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a cfg beat; din is not consumed
// RUN   | moving beats; cnt counts down to the last beat of the packet
module trunc_seq
  import trunc_seq_pkg::*;
#(
  parameter int DIN   = DIN_DEF,
  parameter int NW    = NW_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [LEN_W+NW-1:0] cfg_data,
  input  logic                din_valid,
  output logic                din_ready,
  input  logic [DIN-1:0]      din_data,
  output logic                dout_valid,
  input  logic                dout_ready,
  output logic [DIN-1:0]      dout_data,
  output logic                busy
);

  localparam int NBITS_LSB = nbits_lsb();
  localparam int LEN_LSB   = len_lsb(NW);
  localparam logic [NW-1:0] DIN_NW = NW'(DIN);

  state_t           state;
  logic [LEN_W-1:0] cnt;
  logic [NW-1:0]    nbits_reg;

  logic [NW-1:0]    cfg_nbits;
  logic [LEN_W-1:0] cfg_len;
  logic [NW-1:0]    nbits_clip;
  logic             cfg_fire;
  logic             din_fire;
  logic [DIN-1:0]   masked;

  assign cfg_nbits  = cfg_data[NBITS_LSB +: NW];
  assign cfg_len    = cfg_data[LEN_LSB +: LEN_W];
  assign nbits_clip = (cfg_nbits > DIN_NW) ? DIN_NW : cfg_nbits;

  // Handshake qualifiers; din may only advance when the output slot is free
  // or being emptied this same cycle, which keeps full throughput.
  assign cfg_ready = (state == IDLE);
  assign din_ready = (state == RUN) && (!dout_valid || dout_ready);
  assign cfg_fire  = cfg_valid && cfg_ready;
  assign din_fire  = din_valid && din_ready;
  assign busy      = (state == RUN) || dout_valid;

  // Packet sequencer: latch config in IDLE, count beats down in RUN.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      nbits_reg <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cfg_fire) begin
            nbits_reg <= nbits_clip;
            cnt       <= cfg_len;
            state     <= RUN;
          end
        end
        RUN: begin
          if (din_fire) begin
            if (cnt == '0) begin
              state <= IDLE;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  trunc_seq_mask #(
    .DIN (DIN),
    .NW  (NW)
  ) u_mask (
    .data   (din_data),
    .nbits  (nbits_reg),
    .masked (masked)
  );

  // Output register: load on din handshake, empty on dout handshake.
  // The held beat was masked at load time, so a new cfg cannot alter it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout_valid <= 1'b0;
      dout_data  <= '0;
    end else if (din_fire) begin
      dout_valid <= 1'b1;
      dout_data  <= masked;
    end else if (dout_valid && dout_ready) begin
      dout_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_trunc_seq.sv
// Self-checking bench for trunc_seq: directed packet sequences, a table of
// single-beat truncation vectors, and randomized packets against a model.
module tb_trunc_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [12:0] cfg_data;
  logic        din_valid;
  logic        din_ready;
  logic [15:0] din_data;
  logic        dout_valid;
  logic        dout_ready;
  logic [15:0] dout_data;
  logic        busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  int rdy_mode  = 0;
  logic man_ready = 1'b1;

  logic [15:0] got_q[$];
  int          got_t[$];

  typedef struct {
    int          nbits;
    logic [15:0] din;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[8];

  trunc_seq dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_data   (cfg_data),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .din_data   (din_data),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_data  (dout_data),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      0:       dout_ready = 1'b1;
      1:       dout_ready = ($urandom_range(99) < 70);
      default: dout_ready = man_ready;
    endcase
  end

  always @(negedge clk) begin
    if (rst && dout_valid && dout_ready) begin
      got_q.push_back(dout_data);
      got_t.push_back(cyc);
    end
  end

  function automatic logic [15:0] model(input logic [15:0] d, input int nb);
    int n;
    int v;
    n = (nb > 16) ? 16 : nb;
`ifdef TRUNC_SEQ_ROUND_EN
    if (n == 0) return d;
    if (n == 16) return 16'h0000;
    v = int'(d) + (1 << (n - 1));
    if (v > 65535) v = 65535;
    return 16'((v >> n) << n);
`else
    v = int'(d);
    return 16'((v >> n) << n);
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_cfg(input int len, input int nb);
    bit done = 0;
    cfg_valid = 1'b1;
    cfg_data  = {8'(len), 5'(nb)};
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      if (cfg_ready) done = 1;
      @(posedge clk);
      #1;
    end
    cfg_valid = 1'b0;
    chk("cfg_handshake_timeout", 32'(done), 32'd1);
  endtask

  task automatic send_beats(input logic [15:0] d[$], input int pv);
    int i = 0;
    bit hs;
    for (int k = 0; k < 2000 && i < d.size(); k++) begin
      din_data  = d[i];
      din_valid = ($urandom_range(99) < pv);
      @(negedge clk);
      hs = din_valid && din_ready;
      @(posedge clk);
      #1;
      if (hs) i++;
    end
    din_valid = 1'b0;
    chk("din_handshake_timeout", 32'(i), 32'(d.size()));
  endtask

  task automatic wait_got(input int n);
    bit done = 0;
    for (int k = 0; k < 3000 && !done; k++) begin
      @(negedge clk);
      #1;
      if (got_q.size() >= n) done = 1;
    end
    @(posedge clk);
    #1;
    chk("dout_wait_timeout", 32'(done), 32'd1);
  endtask

  initial begin
    int base;
    logic [15:0] q[$];
    logic [15:0] exp_q[$];
    logic [15:0] held;
    bit stall_ok;
    bit hold_ok;
    bit idle_ok;

`ifdef TRUNC_SEQ_ROUND_EN
    vecs[0] = '{4,  16'h1238, 16'h1240};
    vecs[1] = '{4,  16'h1237, 16'h1230};
    vecs[2] = '{4,  16'hFFF8, 16'hFFF0};
    vecs[3] = '{0,  16'h1234, 16'h1234};
    vecs[4] = '{15, 16'h4000, 16'h8000};
    vecs[5] = '{16, 16'hFFFF, 16'h0000};
    vecs[6] = '{17, 16'h1234, 16'h0000};
    vecs[7] = '{1,  16'h0001, 16'h0002};
`else
    vecs[0] = '{4,  16'h1238, 16'h1230};
    vecs[1] = '{4,  16'h1237, 16'h1230};
    vecs[2] = '{4,  16'hFFF8, 16'hFFF0};
    vecs[3] = '{0,  16'h1234, 16'h1234};
    vecs[4] = '{15, 16'hFFFF, 16'h8000};
    vecs[5] = '{16, 16'hFFFF, 16'h0000};
    vecs[6] = '{17, 16'h1234, 16'h0000};
    vecs[7] = '{1,  16'h0001, 16'h0000};
`endif

    rst       = 1'b0;
    cfg_valid = 1'b0;
    cfg_data  = '0;
    din_valid = 1'b0;
    din_data  = '0;
    #1;
    chk("reset_dout_valid", 32'(dout_valid), 32'd0);
    chk("reset_dout_data", 32'(dout_data), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_cfg_ready", 32'(cfg_ready), 32'd1);
    chk("reset_din_ready", 32'(din_ready), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Test 1: four beats, nbits=4, full throughput
    base = got_q.size();
    send_cfg(3, 4);
    q = '{16'hABCD, 16'h1234, 16'hFFFF, 16'h000F};
    send_beats(q, 100);
    wait_got(base + 4);
`ifdef TRUNC_SEQ_ROUND_EN
    exp_q = '{16'hABD0, 16'h1230, 16'hFFF0, 16'h0010};
`else
    exp_q = '{16'hABC0, 16'h1230, 16'hFFF0, 16'h0000};
`endif
    for (int i = 0; i < 4; i++) chk("t1_beat", 32'(got_q[base+i]), 32'(exp_q[i]));
    chk("t1_back_to_back", 32'(got_t[base+3] - got_t[base]), 32'd3);
    @(negedge clk);
    chk("t1_busy_fall", 32'(busy), 32'd0);
    chk("t1_cfg_ready", 32'(cfg_ready), 32'd1);
    @(posedge clk);
    #1;

    // Test 2: single-beat packets, nbits 0 / 16 / 31
    base = got_q.size();
    exp_q = '{16'hBEEF, 16'h0000, 16'h0000};
    q = '{16'hBEEF};
    send_cfg(0, 0);  send_beats(q, 100);
    send_cfg(0, 16); send_beats(q, 100);
    send_cfg(0, 31); send_beats(q, 100);
    wait_got(base + 3);
    for (int i = 0; i < 3; i++) chk("t2_clip", 32'(got_q[base+i]), 32'(exp_q[i]));

    // Test 3: downstream stall of 5 cycles after beat 3
    base = got_q.size();
    rdy_mode  = 2;
    man_ready = 1'b1;
    q = {};
    for (int i = 0; i < 8; i++) q.push_back(16'(16'h1357 * (i + 1)));
    send_cfg(7, 8);
    stall_ok = 1;
    hold_ok  = 1;
    fork
      send_beats(q, 100);
      begin
        for (int k = 0; k < 200 && got_q.size() < base + 3; k++) begin
          @(negedge clk);
          #1;
        end
        man_ready = 1'b0;
        @(negedge clk);
        held = dout_data;
        for (int k = 0; k < 5; k++) begin
          if (din_ready !== 1'b0 || dout_valid !== 1'b1) stall_ok = 0;
          if (dout_data !== held) hold_ok = 0;
          @(negedge clk);
        end
        man_ready = 1'b1;
      end
    join
    wait_got(base + 8);
    chk("t3_stall_din_ready", 32'(stall_ok), 32'd1);
    chk("t3_stall_hold", 32'(hold_ok), 32'd1);
    for (int i = 0; i < 8; i++) begin
      chk("t3_beat", 32'(got_q[base+i]), 32'(model(q[i], 8)));
      chk("t3_low_byte", 32'(got_q[base+i][7:0]), 32'd0);
    end
    rdy_mode = 0;

    // Test 4: din presented in IDLE is not consumed
    base = got_q.size();
    din_valid = 1'b1;
    din_data  = 16'h5555;
    idle_ok   = 1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (din_ready !== 1'b0 || dout_valid !== 1'b0) idle_ok = 0;
      @(posedge clk);
      #1;
    end
    chk("t4_idle_ignore", 32'(idle_ok), 32'd1);
    send_cfg(0, 1);
    q = '{16'h5555};
    send_beats(q, 100);
    wait_got(base + 1);
`ifdef TRUNC_SEQ_ROUND_EN
    chk("t4_beat", 32'(got_q[base]), 32'h5556);
`else
    chk("t4_beat", 32'(got_q[base]), 32'h5554);
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("t4_single_beat", 32'(got_q.size()), 32'(base + 1));

    // Test 5: asynchronous reset mid-packet
    send_cfg(3, 0);
    q = '{16'h1111, 16'h2222};
    send_beats(q, 100);
    chk("t5_busy_before", 32'(busy), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("t5_rst_dout_valid", 32'(dout_valid), 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("t5_cfg_ready", 32'(cfg_ready), 32'd1);
    @(posedge clk);
    #1;
    base = got_q.size();
    send_cfg(0, 0);
    q = '{16'h2468};
    send_beats(q, 100);
    wait_got(base + 1);
    chk("t5_after_reset", 32'(got_q[base]), 32'h2468);
    repeat (3) @(posedge clk);
    #1;
    chk("t5_no_stale", 32'(got_q.size()), 32'(base + 1));

    // Test 6: table of single-beat vectors
    base = got_q.size();
    foreach (vecs[i]) begin
      send_cfg(0, vecs[i].nbits);
      q = '{vecs[i].din};
      send_beats(q, 100);
    end
    wait_got(base + 8);
    foreach (vecs[i]) chk("t6_vector", 32'(got_q[base+i]), 32'(vecs[i].exp));

    // Randomized packets under random valid / ready
    base  = got_q.size();
    exp_q = {};
    rdy_mode = 1;
    for (int p = 0; p < 30; p++) begin
      int len;
      int nb;
      len = $urandom_range(7);
      nb  = $urandom_range(31);
      q = {};
      for (int i = 0; i <= len; i++) begin
        q.push_back(16'($urandom));
        exp_q.push_back(model(q[i], nb));
      end
      send_cfg(len, nb);
      send_beats(q, 70);
    end
    wait_got(base + exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) chk("rand_beat", 32'(got_q[base+i]), 32'(exp_q[i]));
    rdy_mode = 0;
    repeat (4) @(posedge clk);
    #1;
    chk("rand_no_extra", 32'(got_q.size()), 32'(base + exp_q.size()));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
